mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported, fixed-latency memory between the CPU's instruction-fetch port (read only) and data port (read/write). It sits between the pipelined CPU's `read_m1`/`address1`/`data1` and `read_m2`/`write_m2`/`address2`/`data2` ports and a unified memory model. The data side gets priority, with a starvation guard for fetch. Each side gets a one-cycle `ready` pulse; the CPU stalls its stage until that pulse arrives.

## Interface
- `WORD_SIZE`, 16, address/data width
- `LATENCY`, 2, cycles from memory issue cycle to valid `mem_rdata`; legal range ≥1
- `MAX_D_STREAK`, 4, maximum consecutive D grants while `i_req` is pending; legal range ≥1
- `clk`  in  1  single clock, all state on rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `i_req`  in  1  fetch request, held until `i_ready`
- `i_addr`  in  WORD_SIZE  fetch address, stable while `i_req`
- `i_data`  out  WORD_SIZE  fetched word, valid with `i_ready`, held until next I capture
- `i_ready`  out  1  one-cycle completion pulse for I
- `d_req`  in  1  data request, held until `d_ready`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  WORD_SIZE  data address
- `d_wdata`  in  WORD_SIZE  write data
- `d_rdata`  out  WORD_SIZE  read word, valid with `d_ready` on reads, held otherwise
- `d_ready`  out  1  one-cycle completion pulse for D
- `mem_read`  out  1  memory read strobe, exactly one cycle per read access
- `mem_write`  out  1  memory write strobe, exactly one cycle per write access
- `mem_addr`  out  WORD_SIZE  latched access address
- `mem_wdata`  out  WORD_SIZE  latched write data
- `mem_rdata`  in  WORD_SIZE  memory read data, valid in cycle ISSUE+LATENCY
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- FSM has four states: IDLE, ISSUE, WAIT, RESP. Transitions:
  - IDLE→ISSUE on any grant.
  - ISSUE→WAIT, loading `cnt`=LATENCY-1.
  - WAIT: decrement `cnt` each cycle. When `cnt`==0, capture `mem_rdata` and go to RESP.
  - RESP→IDLE unconditionally.
- Arbitration happens only in IDLE:
  - Grant D if `d_req` && (!`i_req` || `streak` < MAX_D_STREAK).
  - Otherwise grant I if `i_req`.
  - If both are low, stay in IDLE.
- `streak` counter:
  - Increments, saturating at MAX_D_STREAK, on a D grant with `i_req`=1.
  - Clears on any I grant, or on a D grant with `i_req`=0.
- On grant, latch owner, `we` (0 for I), address and wdata. `mem_addr`/`mem_wdata` come from these latches and are stable from ISSUE through RESP.
- In ISSUE only: `mem_read` = !we and `mem_write` = we.
- Read capture updates only the owner's data register. Writes never modify `d_rdata`.
- In RESP, the owner's `ready` = 1; the other side's `ready` = 0.
- Requesters sample `ready` at the edge ending RESP:
  - A requester that drops `req` on that edge is not re-granted.
  - A requester that keeps `req` high is treated as a new request in IDLE.
- Requests arriving while state ≠ IDLE wait; they are never dropped.
- `i_req`/`d_req` changes outside IDLE have no effect on the access in flight.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE; `cnt` and `streak` go to 0.
  - `i_data`, `d_rdata`, `mem_addr`, `mem_wdata` go to 0.
  - `i_ready`, `d_ready`, `mem_read`, `mem_write`, `busy` go to 0.
- Reset mid-access: strobes drop in the same cycle, no `ready` pulse is issued, and in-flight data is discarded.
- Grant decided at the edge ending IDLE cycle 0. ISSUE is cycle 1. `mem_rdata` is captured at the end of cycle 1+LATENCY. RESP (`ready`=1) is cycle 2+LATENCY.
- Request-to-ready latency is LATENCY+2 cycles. Back-to-back access period is LATENCY+3 cycles.
- When LATENCY=1, WAIT lasts exactly one cycle, with `cnt`=0 on entry.
- All outputs are registered or decoded from registered state only. There are no combinational paths from `*_req` to any output.

## Test plan
- **Reset defaults:** hold `reset_n`=0 → every output 0, `busy`=0. Assert reset during WAIT → strobes and `busy` drop in the same cycle and no `ready` pulse follows.
- **Single I read:** LATENCY=2, `i_req`=1, `i_addr`=0x0010, memory returns 0xA5A5 → `mem_read` high only in cycle 1, `i_ready` pulses in cycle 4 with `i_data`=0xA5A5, `d_ready` stays 0.
- **D write:** `d_req`=1, `d_we`=1, `d_addr`=0x0040, `d_wdata`=0x1234 → `mem_write` is one cycle with addr 0x0040 and data 0x1234, `d_ready` pulses in cycle 4, `d_rdata` unchanged.
- **Simultaneous requests:** `i_req` and `d_req` rise in the same IDLE cycle → D served first, I granted in the next IDLE cycle, with I ready 5 cycles after D ready.
- **Starvation guard:** MAX_D_STREAK=4, both `req` held high → D, D, D, D, I, D… grant order. With `i_req` low, D is granted indefinitely and `streak` stays 0.
- **Latency sweep:** LATENCY=1 and LATENCY=5 → `ready` arrives in cycle LATENCY+2, and the captured data equals `mem_rdata` driven only in cycle 1+LATENCY (garbage driven in all other cycles).

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between the CPU fetch (I) and data (D) ports.
// D wins arbitration, but a bounded D streak keeps a pending fetch from starving.
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int LATENCY      = 2,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_data,
    output logic                 i_ready,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy
);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int SW = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [SW-1:0]        streak_q, streak_d;
    logic                 owner_q, we_q;
    logic [WORD_SIZE-1:0] i_data_q, d_rdata_q, addr_q, wdata_q;
    logic                 i_ready_q, d_ready_q, read_q, write_q, busy_q;
    logic                 d_win, i_win;

    assign d_win    = d_req && (!i_req || streak_q < SW'(MAX_D_STREAK));
    assign i_win    = i_req && !d_win;
    // a D grant only counts toward the streak while fetch is actually waiting
    assign streak_d = (d_win && i_req) ? streak_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            streak_q  <= '0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (d_win || i_win) begin
                    state_q  <= ISSUE;
                    busy_q   <= 1'b1;
                    owner_q  <= d_win;
                    we_q     <= d_win && d_we;
                    addr_q   <= d_win ? d_addr : i_addr;
                    wdata_q  <= d_win ? d_wdata : '0;
                    read_q   <= !(d_win && d_we);
                    write_q  <= d_win && d_we;
                    streak_q <= streak_d;
                end
                ISSUE: begin
                    state_q <= WAIT;
                    cnt_q   <= CW'(LATENCY - 1);
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
                WAIT: if (cnt_q == '0) begin
                    state_q   <= RESP;
                    i_ready_q <= !owner_q;
                    d_ready_q <= owner_q;
                    if (!we_q && owner_q) d_rdata_q <= mem_rdata;
                    if (!we_q && !owner_q) i_data_q <= mem_rdata;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                RESP: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    i_ready_q <= 1'b0;
                    d_ready_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_data    = i_data_q;
    assign i_ready   = i_ready_q;
    assign d_rdata   = d_rdata_q;
    assign d_ready   = d_ready_q;
    assign mem_read  = read_q;
    assign mem_write = write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random requesters and a transaction-level timing/memory model
// drive three arbiters (LATENCY 2, 1, 5) and compare every output each cycle.
module tb_mem_port_arbiter;
    logic clk;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit roll(input int p);
        return $urandom_range(99, 0) < p;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int L    = (g == 0) ? 2 : (g == 1) ? 1 : 5;
        localparam int NCYC = 3000;
        logic        rst_n;
        logic        i_req, d_req, d_we;
        logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
        logic [15:0] i_data, d_rdata, mem_addr, mem_wdata;
        logic        i_ready, d_ready, mem_read, mem_write, busy;
        bit          done = 1'b0;

        mem_port_arbiter #(.WORD_SIZE(16), .LATENCY(L), .MAX_D_STREAK(4)) dut (
            .clk(clk), .reset_n(rst_n),
            .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ready(i_ready),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_rdata(d_rdata), .d_ready(d_ready),
            .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
            .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
        );

        initial begin
            logic [15:0] mem [16];
            logic [15:0] addr, wdata, exp_i, exp_d;
            int          free_at, issue, resp, streak, hold, rst_cnt, pi, pd, ki, kd;
            bit          act, own_d, we, ri, rd;
            string       p;
            p = $sformatf("L%0d ", L);
            rst_n = 1'b0; i_req = 0; d_req = 0; d_we = 0;
            i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
            for (int k = 0; k < 16; k++) mem[k] = 16'($urandom);
            act = 0; own_d = 0; we = 0; addr = 0; wdata = 0; issue = 0; resp = 0;
            streak = 0; free_at = 0; exp_i = 0; exp_d = 0; hold = 0; rst_cnt = 0;
            @(negedge clk);
            check({p, "rst i_data"}, i_data, 16'h0);
            check({p, "rst d_rdata"}, d_rdata, 16'h0);
            check({p, "rst mem_addr"}, mem_addr, 16'h0);
            check({p, "rst mem_wdata"}, mem_wdata, 16'h0);
            check({p, "rst flags"}, {11'h0, i_ready, d_ready, mem_read, mem_write, busy}, 16'h0);
            rst_n = 1'b1;
            for (int c = 1; c < NCYC; c++) begin
                @(negedge clk);
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) rst_n = 1'b1;
                    continue;
                end
                mem_rdata = (act && !we && c == issue + L) ? mem[addr[3:0]] : 16'($urandom);
                if (act && c == resp && !we) begin
                    if (own_d) exp_d = mem[addr[3:0]];
                    else exp_i = mem[addr[3:0]];
                end
                check({p, "i_ready"}, 16'(i_ready), 16'(act && c == resp && !own_d));
                check({p, "d_ready"}, 16'(d_ready), 16'(act && c == resp && own_d));
                check({p, "mem_read"}, 16'(mem_read), 16'(act && c == issue && !we));
                check({p, "mem_write"}, 16'(mem_write), 16'(act && c == issue && we));
                check({p, "busy"}, 16'(busy), 16'(act && c >= issue && c <= resp));
                check({p, "i_data"}, i_data, exp_i);
                check({p, "d_rdata"}, d_rdata, exp_d);
                if (act && c >= issue && c <= resp) begin
                    check({p, "mem_addr"}, mem_addr, addr);
                    if (we) check({p, "mem_wdata"}, mem_wdata, wdata);
                end
                if (act && rst_cnt < 2 && c > 600 * (rst_cnt + 1) &&
                    c == issue + rst_cnt) begin
                    rst_n = 1'b0; i_req = 0; d_req = 0;
                    #1;
                    check({p, "midrst flags"}, {11'h0, i_ready, d_ready, mem_read, mem_write, busy}, 16'h0);
                    check({p, "midrst mem_addr"}, mem_addr, 16'h0);
                    act = 0; streak = 0; free_at = 0; exp_i = 0; exp_d = 0;
                    hold = 2; rst_cnt++;
                    continue;
                end
                if (act && we && c == issue) mem[addr[3:0]] = wdata;
                if (c < 1000 || c >= 2400) begin pi = 40; pd = 40; ki = 50; kd = 50; end
                else if (c < 1800) begin pi = 100; pd = 100; ki = 100; kd = 100; end
                else begin pi = 0; pd = 100; ki = 0; kd = 100; end
                ri = 0; rd = 0;
                if (act && c == resp) begin
                    act = 0;
                    if (own_d) begin
                        rd = 1;
                        if (roll(kd)) begin
                            d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
                        end else d_req = 0;
                    end else begin
                        ri = 1;
                        if (roll(ki)) i_addr = 16'($urandom);
                        else i_req = 0;
                    end
                end
                if (!i_req && !ri && roll(pi)) begin
                    i_req = 1; i_addr = 16'($urandom);
                end
                if (!d_req && !rd && roll(pd)) begin
                    d_req = 1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
                end
                if (!act && c >= free_at && (i_req || d_req)) begin
                    own_d = d_req && (!i_req || streak < 4);
                    streak = (own_d && i_req) ? streak + 1 : 0;
                    we = own_d && d_we;
                    addr = own_d ? d_addr : i_addr;
                    wdata = d_wdata;
                    act = 1; issue = c + 1; resp = c + 2 + L; free_at = resp + 1;
                end
            end
            done = 1'b1;
        end
    end

    initial begin
        for (int k = 0; k < 20000; k++) begin
            @(posedge clk);
            if (inst[0].done && inst[1].done && inst[2].done) break;
        end
        check("all_done", 16'(inst[0].done && inst[1].done && inst[2].done), 16'h1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
